mux4_rr_arbiter: RTL

Round-robin arbiter and sequencer for a shared 4-to-1 selection path. Up to four requesters present data words. The block grants one requester at a time, routes that requester's word through an internal 4:1 select, and holds the word in a single-entry output register under a valid/ready handshake. It also exports the registered select code (`sel[1]` = S1, `sel[0]` = S0) so that a companion 4:1 mux in the datapath can be steered in lockstep.

---
 rtl/mux4_rr_arbiter.sv | 110 +++++++++++
 1 files changed

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter feeding a single-entry valid/ready output register.
// Exports the registered select code so a companion 4:1 datapath mux can follow it.
module mux4_rr_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        req,
  input  logic [DATA_W-1:0] din0,
  input  logic [DATA_W-1:0] din1,
  input  logic [DATA_W-1:0] din2,
  input  logic [DATA_W-1:0] din3,
  output logic [3:0]        gnt,
  output logic [1:0]        sel,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [1:0]        sel_q, sel_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              busy_q, busy_d;

  logic [1:0]        win_idx;
  logic              win_found;
  logic              slot_free;
  logic              load;
  logic [DATA_W-1:0] din_mux;

  // First asserted request scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  always_comb begin : win_search
    logic [1:0] cand;
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = ptr_q;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Gating with rst_n cancels a grant in the cycle reset asserts.
  assign slot_free = (state_q == EMPTY) || out_ready;
  assign load      = win_found && slot_free && rst_n;

  always_comb begin
    gnt = 4'b0000;
    if (load) begin
      gnt[win_idx] = 1'b1;
    end
  end

  always_comb begin
    case (win_idx)
      2'd0:    din_mux = din0;
      2'd1:    din_mux = din1;
      2'd2:    din_mux = din2;
      default: din_mux = din3;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    data_d  = data_q;
    busy_d  = (state_q == FULL) || (|req);
    if (load) begin
      data_d  = din_mux;
      sel_d   = win_idx;
      ptr_d   = win_idx + 2'd1;
      state_d = FULL;
    end else if ((state_q == FULL) && out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ptr_q   <= 2'd0;
      sel_q   <= 2'd0;
      data_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
    end
  end

  assign sel       = sel_q;
  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign busy      = busy_q;

endmodule
